d16_fetch: RTL and testbench

Instruction fetch unit of the d16 core: owns the fetch program counter, issues reads to the synchronous instruction memory, and hands instruction words with their address to decode under a valid/ready handshake. It consumes the redirect produced by the jump unit (`load` plus target `mem_addr`). On a redirect it flushes every buffered or in-flight word and restarts fetch at the target.

---
 rtl/d16_fetch_pkg.sv | 11 +
 rtl/d16_fetch_skid.sv | 51 +++++
 rtl/d16_fetch.sv | 78 +++++++
 tb/tb_d16_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/d16_fetch_pkg.sv
// Shared constants and types for the d16 instruction fetch unit.
package d16_fetch_pkg;
  localparam logic [15:0] D16_RESET_PC = 16'h0000;

  typedef enum logic {S_WAIT = 1'b0, S_RUN = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
  } fetch_word_t;
endpackage

// File: rtl/d16_fetch_skid.sv
// Two-entry fetch buffer: head (presented to decode) plus one skid entry.
module d16_fetch_skid
  import d16_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = D16_RESET_PC
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        push_i,
  input  fetch_word_t push_word_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [1:0]  cnt_o,
  output fetch_word_t head_o
);
  fetch_word_t head_q, head_d, skid_q, skid_d;
  logic [1:0]  cnt_q, cnt_d, keep;

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    keep   = cnt_q - {1'b0, pop_i};
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      // skid slides into head on pop; a push lands in the first free slot
      if (pop_i) head_d = skid_q;
      if (push_i) begin
        if (keep == 2'd0) head_d = push_word_i;
        else              skid_d = push_word_i;
      end
      cnt_d = keep + {1'b0, push_i};
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      head_q <= '{data: 16'h0000, pc: RESET_PC};
      skid_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = head_q;
endmodule

// File: rtl/d16_fetch.sv
// d16 instruction fetch: PC, memory read issue, redirect handling and
// valid/ready hand-off of instruction words to decode.
module d16_fetch
  import d16_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = D16_RESET_PC
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        load,
  input  logic [15:0] mem_addr,
  output logic        im_re,
  output logic [15:0] im_addr,
  input  logic [15:0] im_data,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);
  fetch_state_e state_q;
  logic [15:0]  fpc_q, fpc_d, ipc_q;
  logic         inflight_q;
  logic [1:0]   cnt;
  logic [2:0]   occ;
  fetch_word_t  head;
  logic         run, redirect, pop, issue, drop, push;

  assign run      = (state_q == S_RUN);
  assign redirect = run & load;
  assign ir_valid = (cnt != 2'd0);
  // the jump word itself is consumed by the redirect, not by a normal pop
  assign pop      = ir_valid & ir_ready & ~redirect;
  assign occ      = {1'b0, cnt} + {2'b0, inflight_q};
  assign issue    = run & (redirect | (occ < (3'd2 + {2'b0, pop})));
  // stale data returns in the redirect cycle itself, so it is dropped there
  assign drop     = redirect & inflight_q;
  assign push     = inflight_q & ~drop;

  assign im_re   = issue;
  assign im_addr = redirect ? mem_addr : fpc_q;

  always_comb begin
    fpc_d = fpc_q;
    if (redirect)   fpc_d = mem_addr + 16'd1;
    else if (issue) fpc_d = fpc_q + 16'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_WAIT;
      fpc_q      <= RESET_PC;
      ipc_q      <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT:  state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
      fpc_q      <= fpc_d;
      inflight_q <= issue;
      if (issue) ipc_q <= im_addr;
    end
  end

  d16_fetch_skid #(.RESET_PC(RESET_PC)) u_skid (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .push_i      (push),
    .push_word_i ('{data: im_data, pc: ipc_q}),
    .pop_i       (pop),
    .flush_i     (redirect),
    .cnt_o       (cnt),
    .head_o      (head)
  );

  assign ir    = head.data;
  assign ir_pc = head.pc;
endmodule

// File: tb/tb_d16_fetch.sv
// Scoreboard bench for d16_fetch: program-order reference stream with
// redirects, stalls, async reset, and a second instance exercising PC wrap.
module tb_d16_fetch;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        load = 1'b0;
  logic        ir_ready = 1'b1;
  logic [15:0] mem_addr = 16'h0000;
  logic        im_re, im_re2, ir_valid, ir_valid2;
  logic [15:0] im_addr, im_addr2, ir, ir_pc, ir2, ir_pc2;
  logic [15:0] im_data = 16'h0000;
  logic [15:0] im_data2 = 16'h0000;
  int          tests = 0;
  int          fails = 0;
  exp_t        sbq[$];
  exp_t        sbq2[$];
  logic [1:0]  lh = 2'b00;

  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] memw(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // synchronous instruction memories, one per DUT
  always @(posedge sys_clk) begin
    if (im_re)  im_data  <= memw(im_addr);
    if (im_re2) im_data2 <= memw(im_addr2);
  end

  d16_fetch dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .load(load), .mem_addr(mem_addr),
    .im_re(im_re), .im_addr(im_addr), .im_data(im_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  d16_fetch #(.RESET_PC(16'hFFFE)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .load(1'b0), .mem_addr(16'h0000),
    .im_re(im_re2), .im_addr(im_addr2), .im_data(im_data2),
    .ir(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .ir_ready(1'b1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // expected program order restarts at s: s, s+1, s+2, ...
  task automatic sb_restart(input logic [15:0] s);
    exp_t e;
    sbq.delete();
    for (int i = 0; i < 4; i++) begin
      e.pc   = s + 16'(i);
      e.data = memw(e.pc);
      sbq.push_back(e);
    end
  endtask

  task automatic sb2_restart();
    exp_t e;
    sbq2.delete();
    for (int i = 0; i < 4; i++) begin
      e.pc   = 16'hFFFE + 16'(i);
      e.data = memw(e.pc);
      sbq2.push_back(e);
    end
  endtask

  // one cycle of stimulus; outputs are sampled by the caller at edge+2
  task automatic cyc(input logic rdy, input logic ld, input logic [15:0] tgt);
    @(posedge sys_clk); #1;
    ir_ready = rdy;
    load     = ld;
    mem_addr = ld ? tgt : 16'($urandom);
    if (ld) sb_restart(tgt);
    #1;
  endtask

  task automatic reset_seq();
    @(posedge sys_clk); #3;
    sys_rst = 1'b1;
    load    = 1'b0;
    #1;
    chk("rst_im_re", im_re, 0);
    chk("rst_im_addr", im_addr, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ir_pc", ir_pc, 16'h0000);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_pc_wrapdut", ir_pc2, 16'hFFFE);
    @(posedge sys_clk); #1;
    sys_rst  = 1'b0;
    ir_ready = 1'b1;
    sb_restart(16'h0000);
    sb2_restart();
    #1;
    chk("boot_c0_im_re", im_re, 0);
    @(posedge sys_clk); #2;
    chk("boot_c1_im_re", im_re, 1);
    chk("boot_c1_im_addr", im_addr, 16'h0000);
    @(posedge sys_clk); #2;
    chk("boot_c2_im_addr", im_addr, 16'h0001);
    chk("boot_c2_ir_valid", ir_valid, 0);
    @(posedge sys_clk); #2;
    chk("boot_c3_ir_valid", ir_valid, 1);
    chk("boot_c3_ir", ir, 16'hA5A5);
    chk("boot_c3_im_addr", im_addr, 16'h0002);
  endtask

  // monitor: pops the scoreboard on every transfer and checks redirect bubbles
  always @(negedge sys_clk) begin : mon
    exp_t        e;
    logic [15:0] nx;
    if (sys_rst) begin
      lh = 2'b00;
    end else begin
      if (lh[0])      chk("redir_bubble", ir_valid, 0);
      else if (lh[1]) chk("redir_target_valid", ir_valid, 1);
      if (ir_valid && ir_ready && !load) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("xfer_pc", ir_pc, e.pc);
          chk("xfer_ir", ir, e.data);
          nx = (sbq.size() != 0) ? sbq[$].pc + 16'd1 : e.pc + 16'd1;
          e.pc   = nx;
          e.data = memw(nx);
          sbq.push_back(e);
        end
      end
      lh = {lh[0], load};
      if (ir_valid2 && sbq2.size() != 0) begin
        e = sbq2.pop_front();
        chk("wrap_pc", ir_pc2, e.pc);
        chk("wrap_ir", ir2, e.data);
      end
    end
  end

  initial begin : drv
    logic [15:0] hir, hpc;
    int          reads;
    repeat (2) @(posedge sys_clk);
    reset_seq();

    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 16'h0);
      chk("stream_no_gap", ir_valid, 1);
    end

    reads = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      chk("stall_valid", ir_valid, 1);
      if (i == 0) begin
        hir = ir;
        hpc = ir_pc;
      end else begin
        chk("stall_ir_hold", ir, hir);
        chk("stall_pc_hold", ir_pc, hpc);
      end
      reads += int'(im_re);
      if (i >= 2) chk("stall_im_re_low", im_re, 0);
    end
    chk("stall_reads_le1", 32'(reads <= 1), 1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0);

    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h0040);
    cyc(1'b1, 1'b0, 16'h0);
    chk("jmp40_bubble", ir_valid, 0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("jmp40_valid", ir_valid, 1);
    chk("jmp40_pc0", ir_pc, 16'h0040);
    cyc(1'b1, 1'b0, 16'h0);
    chk("jmp40_pc1", ir_pc, 16'h0041);

    cyc(1'b1, 1'b1, 16'h0010);
    cyc(1'b1, 1'b1, 16'h0020);
    cyc(1'b1, 1'b0, 16'h0);
    chk("b2b_bubble", ir_valid, 0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("b2b_valid", ir_valid, 1);
    chk("b2b_pc", ir_pc, 16'h0020);

    for (int i = 0; i < 400; i++)
      cyc(1'(($urandom % 4) != 0), 1'(($urandom % 16) == 0), 16'($urandom));

    reset_seq();
    for (int i = 0; i < 150; i++)
      cyc(1'(($urandom % 3) != 0), 1'(($urandom % 12) == 0), 16'($urandom));

    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 16'h0);
    chk("wrap_seq_done", sbq2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
